// File: rtl/vga_pkg.sv
// Shared constants and state type for the VGA display path.
package vga_pkg;
   localparam int unsigned IMG_W        = 320;
   localparam int unsigned IMG_H        = 480;
   localparam int unsigned ADDR_W       = 20;
   localparam int unsigned FRAME_PIXELS = IMG_W * IMG_H;
   localparam int unsigned POS_W        = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } loader_state_t;
endpackage

// File: rtl/pixel_position_counter.sv
// Column-major row/col/address counters; holds at the last pixel of the frame.
module pixel_position_counter
   import vga_pkg::*;
#(
   parameter int unsigned IMG_W  = vga_pkg::IMG_W,
   parameter int unsigned IMG_H  = vga_pkg::IMG_H,
   parameter int unsigned ADDR_W = vga_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   output logic [POS_W-1:0]  col,
   output logic [POS_W-1:0]  row,
   output logic [ADDR_W-1:0] addr,
   output logic              last_c
);
   localparam logic [POS_W-1:0] ROW_MAX = POS_W'(IMG_H - 1);
   localparam logic [POS_W-1:0] COL_MAX = POS_W'(IMG_W - 1);

   logic [POS_W-1:0]  r_col;
   logic [POS_W-1:0]  r_row;
   logic [ADDR_W-1:0] r_addr;

   assign last_c = (r_row == ROW_MAX) && (r_col == COL_MAX);
   assign col    = r_col;
   assign row    = r_row;
   assign addr   = r_addr;

   // Address increments alongside row/col, so it always equals col*IMG_H+row
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col  <= '0;
         r_row  <= '0;
         r_addr <= '0;
      end else if (clr) begin
         r_col  <= '0;
         r_row  <= '0;
         r_addr <= '0;
      end else if (inc && !last_c) begin
         if (r_row == ROW_MAX) begin
            r_row <= '0;
            r_col <= r_col + POS_W'(1);
         end else begin
            r_row <= r_row + POS_W'(1);
         end
         r_addr <= r_addr + ADDR_W'(1);
      end
   end
endmodule

// File: rtl/frame_buffer_loader.sv
// Loads a streamed grayscale frame into the decrypted or encrypted frame memory.
module frame_buffer_loader
   import vga_pkg::*;
#(
   parameter int unsigned IMG_W  = vga_pkg::IMG_W,
   parameter int unsigned IMG_H  = vga_pkg::IMG_H,
   parameter int unsigned ADDR_W = vga_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              buf_sel,
   input  logic [7:0]        pix_data,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic              mem_we_dec,
   output logic              mem_we_enc,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [POS_W-1:0]  col,
   output logic [POS_W-1:0]  row
);
   loader_state_t     r_state;
   loader_state_t     w_next;
   logic              w_clr;
   logic              w_accept;
   logic              w_last;
   logic [ADDR_W-1:0] w_pos_addr;

   logic              r_sel;
   logic              r_we_dec;
   logic              r_we_enc;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_wdata;

   pixel_position_counter #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_pos (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_clr),
      .inc    (w_accept),
      .col    (col),
      .row    (row),
      .addr   (w_pos_addr),
      .last_c (w_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // start is only honoured outside LOAD; a running frame cannot be restarted
   always_comb begin
      w_next   = r_state;
      w_clr    = 1'b0;
      w_accept = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_next = LOAD;
               w_clr  = 1'b1;
            end
         end
         LOAD: begin
            w_accept = pix_valid;
            if (pix_valid && w_last) w_next = DONE;
         end
         default: w_next = IDLE;
      endcase
   end

   // One-cycle write pipeline: address/data captured on the accepting edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel    <= 1'b0;
         r_we_dec <= 1'b0;
         r_we_enc <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_we_dec <= w_accept && !r_sel;
         r_we_enc <= w_accept && r_sel;
         if (w_accept) begin
            r_addr  <= w_pos_addr;
            r_wdata <= pix_data;
         end
         if (w_clr) r_sel <= buf_sel;
      end
   end

   assign pix_ready  = (r_state == LOAD);
   assign busy       = (r_state == LOAD);
   assign done       = (r_state == DONE);
   assign mem_we_dec = r_we_dec;
   assign mem_we_enc = r_we_enc;
   assign mem_addr   = r_addr;
   assign mem_wdata  = r_wdata;
endmodule
